// File: rtl/sp_unit_p.sv
`default_nettype none
// ============================================================================
//  Module   : sp_unit_p
//  Purpose  : Parametrised stack-pointer unit with increment/decrement by
//             STEP, direct load, runtime bounds window [spLow, spHigh],
//             sticky first-cause fault reporting and a low-water mark.
//  Revision : 1.0 - initial release
//
//  Ports
//    clock       in   1      rising-edge clock
//    reset       in   1      synchronous active-high reset
//    spSrc       in   2      00 hold, 01 inc, 10 dec, 11 load spIn
//    spWrite     in   1      op enable (0 = hold)
//    spIn        in   WIDTH  load value
//    spLow       in   WIDTH  lowest legal SP (inclusive)
//    spHigh      in   WIDTH  highest legal SP (inclusive)
//    faultClear  in   1      clears sticky fault, reloads low-water mark
//    spCur       out  WIDTH  current SP
//    spFault     out  1      sticky fault flag
//    faultCode   out  2      first cause: 01 underflow, 10 overflow, 11 load
//    spLowWater  out  WIDTH  minimum SP since reset / last faultClear
// ============================================================================
module sp_unit_p #(
  parameter int unsigned          WIDTH       = 16,
  parameter int unsigned          STEP        = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       spSrc,
  input  logic             spWrite,
  input  logic [WIDTH-1:0] spIn,
  input  logic [WIDTH-1:0] spLow,
  input  logic [WIDTH-1:0] spHigh,
  input  logic             faultClear,
  output logic [WIDTH-1:0] spCur,
  output logic             spFault,
  output logic [1:0]       faultCode,
  output logic [WIDTH-1:0] spLowWater
);

  localparam logic [WIDTH:0] c_STEP = (WIDTH+1)'(STEP);

  localparam logic [1:0] c_OP_HOLD = 2'b00;
  localparam logic [1:0] c_OP_INC  = 2'b01;
  localparam logic [1:0] c_OP_DEC  = 2'b10;
  localparam logic [1:0] c_OP_LOAD = 2'b11;

  localparam logic [1:0] c_CODE_NONE  = 2'b00;
  localparam logic [1:0] c_CODE_UNDER = 2'b01;
  localparam logic [1:0] c_CODE_OVER  = 2'b10;
  localparam logic [1:0] c_CODE_LOAD  = 2'b11;

  typedef enum logic [0:0] {
    ST_OK      = 1'b0,
    ST_FAULTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_code;
  logic [1:0]       w_code_nxt;
  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] r_low_water;
  logic [WIDTH-1:0] w_lw_base;
  logic [WIDTH-1:0] w_lw_nxt;

  logic [WIDTH:0]   w_cand;
  logic [1:0]       w_cause;
  logic             w_active;
  logic             w_legal;
  logic             w_write;
  logic             w_fault;

  // Candidate is one bit wider than SP. An inc that overflows WIDTH and a
  // dec that goes below zero both set the top bit, so a plain unsigned
  // compare against the zero-extended bounds rejects them without a
  // separate carry/borrow check.
  always_comb begin
    w_cand  = {1'b0, r_sp};
    w_cause = c_CODE_NONE;
    case (spSrc)
      c_OP_HOLD: begin
        w_cand  = {1'b0, r_sp};
        w_cause = c_CODE_NONE;
      end
      c_OP_INC: begin
        w_cand  = {1'b0, r_sp} + c_STEP;
        w_cause = c_CODE_OVER;
      end
      c_OP_DEC: begin
        w_cand  = {1'b0, r_sp} - c_STEP;
        w_cause = c_CODE_UNDER;
      end
      c_OP_LOAD: begin
        w_cand  = {1'b0, spIn};
        w_cause = c_CODE_LOAD;
      end
      default: begin
        w_cand  = {1'b0, r_sp};
        w_cause = c_CODE_NONE;
      end
    endcase
  end

  assign w_active = spWrite && (spSrc != c_OP_HOLD);
  assign w_legal  = (w_cand >= {1'b0, spLow}) && (w_cand <= {1'b0, spHigh});
  assign w_write  = w_active && w_legal;
  assign w_fault  = w_active && !w_legal;

  // Fault FSM: a new fault always wins over a same-cycle clear; while
  // already faulted (and not clearing) the first cause is kept.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    if (w_fault) begin
      w_state_nxt = ST_FAULTED;
      if ((r_state == ST_OK) || faultClear) begin
        w_code_nxt = w_cause;
      end
    end else if (faultClear) begin
      w_state_nxt = ST_OK;
      w_code_nxt  = c_CODE_NONE;
    end
  end

  // Clear restarts tracking from the pre-update SP; a same-cycle write is
  // then folded in by the min.
  always_comb begin
    w_lw_base = faultClear ? r_sp : r_low_water;
    w_lw_nxt  = w_lw_base;
    if (w_write && (w_cand[WIDTH-1:0] < w_lw_base)) begin
      w_lw_nxt = w_cand[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_OK;
      r_code      <= c_CODE_NONE;
      r_sp        <= RESET_VALUE;
      r_low_water <= RESET_VALUE;
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_low_water <= w_lw_nxt;
      if (w_write) begin
        r_sp <= w_cand[WIDTH-1:0];
      end
    end
  end

  assign spCur      = r_sp;
  assign spFault    = (r_state == ST_FAULTED);
  assign faultCode  = r_code;
  assign spLowWater = r_low_water;

endmodule
`default_nettype wire

// File: tb/tb_sp_unit_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sp_unit_p
//  Purpose  : Directed self-checking bench for sp_unit_p. Instance A uses
//             STEP=1, RESET_VALUE=0x0100; instance B uses STEP=2,
//             RESET_VALUE=0x0001.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sp_unit_p;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A stimulus / observation
  logic        a_reset, a_spWrite, a_faultClear;
  logic [1:0]  a_spSrc;
  logic [15:0] a_spIn, a_spLow, a_spHigh;
  logic [15:0] a_spCur, a_spLowWater;
  logic        a_spFault;
  logic [1:0]  a_faultCode;

  // Instance B stimulus / observation
  logic        b_reset, b_spWrite, b_faultClear;
  logic [1:0]  b_spSrc;
  logic [15:0] b_spIn, b_spLow, b_spHigh;
  logic [15:0] b_spCur, b_spLowWater;
  logic        b_spFault;
  logic [1:0]  b_faultCode;

  int n_cmp = 0;
  int n_err = 0;

  sp_unit_p #(.WIDTH(16), .STEP(1), .RESET_VALUE(16'h0100)) u_dut_a (
    .clock      (clock),
    .reset      (a_reset),
    .spSrc      (a_spSrc),
    .spWrite    (a_spWrite),
    .spIn       (a_spIn),
    .spLow      (a_spLow),
    .spHigh     (a_spHigh),
    .faultClear (a_faultClear),
    .spCur      (a_spCur),
    .spFault    (a_spFault),
    .faultCode  (a_faultCode),
    .spLowWater (a_spLowWater)
  );

  sp_unit_p #(.WIDTH(16), .STEP(2), .RESET_VALUE(16'h0001)) u_dut_b (
    .clock      (clock),
    .reset      (b_reset),
    .spSrc      (b_spSrc),
    .spWrite    (b_spWrite),
    .spIn       (b_spIn),
    .spLow      (b_spLow),
    .spHigh     (b_spHigh),
    .faultClear (b_faultClear),
    .spCur      (b_spCur),
    .spFault    (b_spFault),
    .faultCode  (b_faultCode),
    .spLowWater (b_spLowWater)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [15:0] sp, input logic f,
                       input logic [1:0] code, input logic [15:0] lw);
    chk({tag, ".spCur"},      a_spCur,               sp);
    chk({tag, ".spFault"},    {15'd0, a_spFault},    {15'd0, f});
    chk({tag, ".faultCode"},  {14'd0, a_faultCode},  {14'd0, code});
    chk({tag, ".spLowWater"}, a_spLowWater,          lw);
  endtask

  task automatic chk_b(input string tag, input logic [15:0] sp, input logic f,
                       input logic [1:0] code);
    chk({tag, ".spCur"},     b_spCur,              sp);
    chk({tag, ".spFault"},   {15'd0, b_spFault},   {15'd0, f});
    chk({tag, ".faultCode"}, {14'd0, b_faultCode}, {14'd0, code});
  endtask

  task automatic op_a(input logic [1:0] src, input logic wr,
                      input logic [15:0] din, input logic clr);
    a_spSrc = src; a_spWrite = wr; a_spIn = din; a_faultClear = clr;
    tick();
    a_spSrc = 2'b00; a_spWrite = 1'b0; a_faultClear = 1'b0;
  endtask

  task automatic op_b(input logic [1:0] src, input logic wr,
                      input logic [15:0] din, input logic clr);
    b_spSrc = src; b_spWrite = wr; b_spIn = din; b_faultClear = clr;
    tick();
    b_spSrc = 2'b00; b_spWrite = 1'b0; b_faultClear = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_spSrc = 2'b00; a_spWrite = 1'b0; a_spIn = 16'h0000;
    a_spLow = 16'h0000; a_spHigh = 16'hFFFF; a_faultClear = 1'b0;
    b_reset = 1'b1; b_spSrc = 2'b00; b_spWrite = 1'b0; b_spIn = 16'h0000;
    b_spLow = 16'h0000; b_spHigh = 16'hFFFF; b_faultClear = 1'b0;

    // ---------------- Instance A: STEP=1, reset value 0x0100 -------------
    tick();
    tick();
    chk_a("a_reset", 16'h0100, 1'b0, 2'b00, 16'h0100);
    a_reset = 1'b0;

    op_a(2'b10, 1'b1, 16'h0000, 1'b0);
    chk("a_dec1", a_spCur, 16'h00FF);
    op_a(2'b10, 1'b1, 16'h0000, 1'b0);
    chk("a_dec2", a_spCur, 16'h00FE);
    op_a(2'b10, 1'b1, 16'h0000, 1'b0);
    chk("a_dec3", a_spCur, 16'h00FD);
    op_a(2'b01, 1'b1, 16'h0000, 1'b0);
    chk_a("a_inc1", 16'h00FE, 1'b0, 2'b00, 16'h00FD);

    // Back to 0x00FD, then underflow against spLow
    op_a(2'b10, 1'b1, 16'h0000, 1'b0);
    chk("a_dec4", a_spCur, 16'h00FD);
    a_spLow = 16'h00FD;
    op_a(2'b10, 1'b1, 16'h0000, 1'b0);
    chk_a("a_underflow", 16'h00FD, 1'b1, 2'b01, 16'h00FD);

    // Overflow while faulted: first cause retained
    a_spHigh = 16'h00FD;
    op_a(2'b01, 1'b1, 16'h0000, 1'b0);
    chk_a("a_keep_cause", 16'h00FD, 1'b1, 2'b01, 16'h00FD);

    // Clear together with a legal load
    a_spLow = 16'h0000; a_spHigh = 16'hFFFF;
    op_a(2'b11, 1'b1, 16'h0080, 1'b1);
    chk_a("a_clr_load", 16'h0080, 1'b0, 2'b00, 16'h0080);

    // Inverted window: hold is fine, inc faults with overflow
    a_spLow = 16'h0010; a_spHigh = 16'h000F;
    op_a(2'b00, 1'b1, 16'h0000, 1'b0);
    chk_a("a_inv_hold", 16'h0080, 1'b0, 2'b00, 16'h0080);
    op_a(2'b01, 1'b1, 16'h0000, 1'b0);
    chk_a("a_inv_inc", 16'h0080, 1'b1, 2'b10, 16'h0080);

    // Clear alone, then clear racing an illegal dec (fault wins, new code)
    op_a(2'b00, 1'b0, 16'h0000, 1'b1);
    chk_a("a_clr", 16'h0080, 1'b0, 2'b00, 16'h0080);
    op_a(2'b01, 1'b1, 16'h0000, 1'b0);
    chk("a_refault.faultCode", {14'd0, a_faultCode}, 16'h0002);
    op_a(2'b10, 1'b1, 16'h0000, 1'b1);
    chk_a("a_clr_vs_fault", 16'h0080, 1'b1, 2'b01, 16'h0080);

    // spWrite=0 with inc request: nothing moves for 5 cycles
    a_spLow = 16'h0000; a_spHigh = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      op_a(2'b01, 1'b0, 16'h0000, 1'b0);
      chk("a_nowrite.spCur", a_spCur, 16'h0080);
    end
    chk_a("a_nowrite_end", 16'h0080, 1'b1, 2'b01, 16'h0080);

    // Reset asserted during an illegal load
    a_spLow = 16'h0010; a_spHigh = 16'h000F;
    a_reset = 1'b1;
    op_a(2'b11, 1'b1, 16'h1234, 1'b0);
    chk_a("a_reset_vs_fault", 16'h0100, 1'b0, 2'b00, 16'h0100);
    a_reset = 1'b0;

    // ---------------- Instance B: STEP=2, reset value 0x0001 -------------
    chk_b("b_reset", 16'h0001, 1'b0, 2'b00);
    b_reset = 1'b0;
    op_b(2'b01, 1'b1, 16'h0000, 1'b0);
    chk("b_inc2", b_spCur, 16'h0003);
    op_b(2'b10, 1'b1, 16'h0000, 1'b0);
    chk("b_dec2", b_spCur, 16'h0001);
    chk("b_lowwater", b_spLowWater, 16'h0001);
    op_b(2'b10, 1'b1, 16'h0000, 1'b0);
    chk_b("b_below_zero", 16'h0001, 1'b1, 2'b01);

    b_spHigh = 16'h01FF;
    op_b(2'b11, 1'b1, 16'h0200, 1'b0);
    chk_b("b_load_no_clr", 16'h0001, 1'b1, 2'b01);
    op_b(2'b00, 1'b0, 16'h0000, 1'b1);
    chk_b("b_clr", 16'h0001, 1'b0, 2'b00);
    op_b(2'b11, 1'b1, 16'h0200, 1'b0);
    chk_b("b_bad_load", 16'h0001, 1'b1, 2'b11);
    op_b(2'b11, 1'b1, 16'h01FF, 1'b0);
    chk_b("b_edge_load", 16'h01FF, 1'b1, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
